cc_rdata_serializer: RTL and testbench
======================================

# cc_rdata_serializer

Read-data return path of the cache controller. Consumes ordered hit/miss results produced behind the address decoder: hit lines from the hit data FIFO, miss lines from the refill path. Returns each 512-bit line to the interconnect as an 8-beat, 64-bit AXI read burst. Request order is preserved by the hit flag FIFO, which holds one entry per accepted AR handshake.

## Interface
Parameters: none. Line = 512 bits, beat = 64 bits, burst = 8 beats, all fixed.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- hit_flag_fifo_empty_i  input  1  flag FIFO empty (show-ahead FIFO)
- hit_flag_fifo_rdata_i  input  1  head flag: 1 = hit, 0 = miss
- hit_flag_fifo_rden_o  output  1  pop flag FIFO
- hit_data_fifo_empty_i  input  1  hit data FIFO empty (show-ahead FIFO)
- hit_data_fifo_rdata_i  input  518  {offset[5:0], line[511:0]}
- hit_data_fifo_rden_o  output  1  pop hit data FIFO
- miss_data_valid_i  input  1  refill line valid
- miss_data_i  input  512  refill line
- miss_offset_i  input  6  original request offset
- miss_data_ready_o  output  1  refill line accepted when valid & ready
- inct_rdata_o  output  64  AXI R data
- inct_rresp_o  output  2  constant 2'b00 (OKAY)
- inct_rlast_o  output  1  last beat of burst
- inct_rvalid_o  output  1  R valid
- inct_rready_i  input  1  R ready

## Operation
FSM states: IDLE, WAIT_DATA, SEND.

- IDLE
  - If !hit_flag_fifo_empty_i: assert hit_flag_fifo_rden_o for one cycle, latch flag into is_hit, go to WAIT_DATA.
  - Otherwise stay in IDLE.
- WAIT_DATA, is_hit=1
  - If !hit_data_fifo_empty_i: assert hit_data_fifo_rden_o for one cycle.
  - Load line buffer and start pointer, clear beat count, go to SEND.
- WAIT_DATA, is_hit=0
  - miss_data_ready_o = 1, combinational, in this state only.
  - On miss_data_valid_i: load line buffer and pointer, go to SEND.
- Start pointer = offset[5:3], 3 bits.
- SEND
  - inct_rvalid_o = 1.
  - inct_rdata_o = line[ptr*64 +: 64].
  - inct_rlast_o = (cnt == 7).
  - On inct_rvalid_o & inct_rready_i: ptr = ptr+1 (3-bit wrap 7→0), cnt = cnt+1.
  - If the handshake was on the last beat, go to IDLE.
- Offset bits [2:0] are ignored.
- All three pop/ready outputs are decoded from state, so at most one is high in any cycle.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE; is_hit, ptr and cnt = 0; line buffer = 0.
  - All outputs 0: rvalid, rlast, rdata, all pops, miss_data_ready_o.
- Reset mid-burst abandons the burst. The pending FIFO entry is not restored.
- Latency:
  - Flag visible at cycle T → flag pop at T.
  - Data available at T+1 → data pop or miss accept at T+1.
  - First beat valid at T+2.
- Throughput: a burst holds SEND for at least 8 cycles. Minimum gap between bursts is 2 cycles with rvalid low.
- AXI rules:
  - While rvalid & !rready, rdata and rlast are held stable.
  - rvalid never drops before its handshake.
- Boundary conditions:
  - Flag FIFO empty → block idles indefinitely.
  - Data not yet available → wait in WAIT_DATA indefinitely, no timeout.
  - Miss data presented while is_hit=1 or outside WAIT_DATA → not accepted (ready low).
  - rready low for any number of cycles → beat held.

## Configuration
- CC_RDATA_CWF_EN defined: critical-word-first wrapping. The burst starts at beat offset[5:3] and wraps modulo 8.
- CC_RDATA_CWF_EN undefined: start pointer is always 0 and offset is ignored. Beats go out 0..7 in address order.
- Handshakes and latency are identical in both builds.

## Test plan
- Hit, offset=0x00, rready=1, line beats k = 64'h1111_1111_1111_1111*k: flag pop at T, data pop at T+1, beats 0..7 on T+2..T+9, rlast only at T+9, rresp = 0.
- Hit, offset=0x28 with CC_RDATA_CWF_EN: beat order 5,6,7,0,1,2,3,4. Without the macro: order 0..7.
- Miss, miss_data_valid_i asserted 10 cycles after the flag pop: miss_data_ready_o high for all of WAIT_DATA. Accept occurs on the valid cycle; first beat follows on the next cycle.
- Backpressure: rready toggled 1,0,0,1,… during a burst: rdata and rlast stable while stalled, exactly 8 handshakes, rlast on the 8th.
- Ordering: flags hit, miss, hit queued, with miss data arriving before the second hit's data is needed. Bursts return in flag order; the idle gap between bursts is ≥2 cycles.
- Assert rst in the 4th beat: rvalid drops immediately and all outputs are 0. After release, the next queued flag is processed normally.

Source files
------------

// File: rtl/cc_rdata_serializer.sv
// cc_rdata_serializer: returns 512-bit hit/miss lines as 8-beat 64-bit AXI read bursts in request order.
// Ports: clk, rst (async, active-high); hit flag FIFO (empty/rdata in, rden out);
// hit data FIFO {offset[5:0], line[511:0]} (empty/rdata in, rden out);
// refill line (valid/data/offset in, ready out); AXI R channel (rdata/rresp/rlast/rvalid out, rready in).
// Build option: CC_RDATA_CWF_EN enables critical-word-first (burst starts at offset[5:3], wraps mod 8).
module cc_rdata_serializer (
  input  logic         clk,
  input  logic         rst,
  input  logic         hit_flag_fifo_empty_i,
  input  logic         hit_flag_fifo_rdata_i,
  output logic         hit_flag_fifo_rden_o,
  input  logic         hit_data_fifo_empty_i,
  input  logic [517:0] hit_data_fifo_rdata_i,
  output logic         hit_data_fifo_rden_o,
  input  logic         miss_data_valid_i,
  input  logic [511:0] miss_data_i,
  input  logic [5:0]   miss_offset_i,
  output logic         miss_data_ready_o,
  output logic [63:0]  inct_rdata_o,
  output logic [1:0]   inct_rresp_o,
  output logic         inct_rlast_o,
  output logic         inct_rvalid_o,
  input  logic         inct_rready_i
);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, SEND} state_t;
  state_t       state;
  logic         is_hit;
  logic [2:0]   ptr;
  logic [2:0]   cnt;
  logic [511:0] line;
  logic [511:0] ld_line;
  logic [5:0]   ld_off;
  logic [2:0]   start_ptr;
  logic         ld;
  logic         unused_ok;
  // pops are gated by rst so a queued entry is never consumed while reset is held
  assign hit_flag_fifo_rden_o = !rst && state == IDLE && !hit_flag_fifo_empty_i;
  assign hit_data_fifo_rden_o = !rst && state == WAIT_DATA && is_hit && !hit_data_fifo_empty_i;
  assign miss_data_ready_o    = !rst && state == WAIT_DATA && !is_hit;
  assign ld      = hit_data_fifo_rden_o || (miss_data_ready_o && miss_data_valid_i);
  assign ld_line = is_hit ? hit_data_fifo_rdata_i[511:0] : miss_data_i;
  assign ld_off  = is_hit ? hit_data_fifo_rdata_i[517:512] : miss_offset_i;
`ifdef CC_RDATA_CWF_EN
  assign start_ptr = ld_off[5:3];
  assign unused_ok = ^ld_off[2:0];
`else
  assign start_ptr = 3'd0;
  assign unused_ok = ^ld_off;
`endif
  assign inct_rvalid_o = state == SEND;
  assign inct_rdata_o  = inct_rvalid_o ? line[{ptr, 6'd0} +: 64] : 64'd0;
  assign inct_rlast_o  = inct_rvalid_o && cnt == 3'd7;
  assign inct_rresp_o  = 2'b00;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      is_hit <= 1'b0;
      ptr    <= 3'd0;
      cnt    <= 3'd0;
      line   <= '0;
    end else begin
      case (state)
        IDLE: if (hit_flag_fifo_rden_o) begin
          is_hit <= hit_flag_fifo_rdata_i;
          state  <= WAIT_DATA;
        end
        WAIT_DATA: if (ld) begin
          line  <= ld_line;
          ptr   <= start_ptr;
          cnt   <= 3'd0;
          state <= SEND;
        end
        SEND: if (inct_rready_i) begin
          ptr <= ptr + 3'd1;
          cnt <= cnt + 3'd1;
          state <= cnt == 3'd7 ? IDLE : SEND;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cc_rdata_serializer.sv
// tb_cc_rdata_serializer: scoreboard bench for cc_rdata_serializer with show-ahead FIFO models.
module tb_cc_rdata_serializer;
`ifdef CC_RDATA_CWF_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst;
  logic         hit_flag_fifo_empty_i;
  logic         hit_flag_fifo_rdata_i;
  logic         hit_flag_fifo_rden_o;
  logic         hit_data_fifo_empty_i;
  logic [517:0] hit_data_fifo_rdata_i;
  logic         hit_data_fifo_rden_o;
  logic         miss_data_valid_i;
  logic [511:0] miss_data_i;
  logic [5:0]   miss_offset_i;
  logic         miss_data_ready_o;
  logic [63:0]  inct_rdata_o;
  logic [1:0]   inct_rresp_o;
  logic         inct_rlast_o;
  logic         inct_rvalid_o;
  logic         inct_rready_i;

  cc_rdata_serializer dut (
    .clk(clk), .rst(rst),
    .hit_flag_fifo_empty_i(hit_flag_fifo_empty_i), .hit_flag_fifo_rdata_i(hit_flag_fifo_rdata_i),
    .hit_flag_fifo_rden_o(hit_flag_fifo_rden_o),
    .hit_data_fifo_empty_i(hit_data_fifo_empty_i), .hit_data_fifo_rdata_i(hit_data_fifo_rdata_i),
    .hit_data_fifo_rden_o(hit_data_fifo_rden_o),
    .miss_data_valid_i(miss_data_valid_i), .miss_data_i(miss_data_i), .miss_offset_i(miss_offset_i),
    .miss_data_ready_o(miss_data_ready_o),
    .inct_rdata_o(inct_rdata_o), .inct_rresp_o(inct_rresp_o), .inct_rlast_o(inct_rlast_o),
    .inct_rvalid_o(inct_rvalid_o), .inct_rready_i(inct_rready_i)
  );

  always #5 clk = ~clk;

  logic         flag_q[$];
  logic [517:0] data_q[$];
  logic [64:0]  sb[$];
  int           total = 0;
  int           bad = 0;
  int           hs_cnt = 0;
  logic         pf_flag = 1'b0;
  logic         pf_data = 1'b0;

  task automatic refresh();
    hit_flag_fifo_empty_i = flag_q.size() == 0;
    hit_flag_fifo_rdata_i = flag_q.size() != 0 ? flag_q[0] : 1'b0;
    hit_data_fifo_empty_i = data_q.size() == 0;
    hit_data_fifo_rdata_i = data_q.size() != 0 ? data_q[0] : '0;
  endtask

  // FIFO model: a pop requested during a cycle takes effect just after the rising edge
  always @(negedge clk) begin
    pf_flag = hit_flag_fifo_rden_o;
    pf_data = hit_data_fifo_rden_o;
  end
  always @(posedge clk) begin
    logic         fd;
    logic [517:0] dd;
    #1;
    if (pf_flag && flag_q.size() != 0) fd = flag_q.pop_front();
    if (pf_data && data_q.size() != 0) dd = data_q.pop_front();
    pf_flag = 1'b0;
    pf_data = 1'b0;
    refresh();
  end

  function automatic logic [511:0] mk_line(input logic [63:0] base, input logic [63:0] step);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + step * 64'(k);
    return l;
  endfunction

  task automatic push_exp(input logic [5:0] off, input logic [511:0] l);
    int s;
    s = CWF ? int'(off[5:3]) : 0;
    for (int i = 0; i < 8; i++) sb.push_back({i == 7, l[((s + i) % 8)*64 +: 64]});
  endtask

  task automatic queue_hit(input logic [5:0] off, input logic [511:0] l, input bit with_data);
    flag_q.push_back(1'b1);
    if (with_data) data_q.push_back({off, l});
    push_exp(off, l);
    refresh();
  endtask

  // Monitor: beat scoreboard, AXI hold-while-stalled, inter-burst gap
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;
  logic        prev_v = 1'b0;
  bit          seen = 1'b0;
  int          low_run = 0;
  logic [64:0] exp_beat;
  always @(negedge clk) begin
    if (prev_stall) begin
      total++;
      if (inct_rvalid_o !== 1'b1 || inct_rdata_o !== prev_data || inct_rlast_o !== prev_last) begin
        bad++;
        $display("FAIL hold: got v=%b d=%h l=%b, need v=1 d=%h l=%b", inct_rvalid_o, inct_rdata_o, inct_rlast_o, prev_data, prev_last);
      end
    end
    if (inct_rvalid_o && !prev_v && seen) begin
      total++;
      if (low_run < 2) begin
        bad++;
        $display("FAIL gap: got %0d idle cycles, need >=2", low_run);
      end
    end
    if (inct_rvalid_o) begin
      seen = 1'b1;
      low_run = 0;
    end else low_run++;
    if (inct_rvalid_o && inct_rready_i) begin
      hs_cnt++;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL beat: got unexpected beat d=%h l=%b", inct_rdata_o, inct_rlast_o);
      end else begin
        exp_beat = sb.pop_front();
        if ({inct_rresp_o, inct_rlast_o, inct_rdata_o} !== {2'b00, exp_beat}) begin
          bad++;
          $display("FAIL beat: got r=%b l=%b d=%h, need r=00 l=%b d=%h", inct_rresp_o, inct_rlast_o, inct_rdata_o, exp_beat[64], exp_beat[63:0]);
        end
      end
    end
    prev_stall = inct_rvalid_o && !inct_rready_i;
    prev_data = inct_rdata_o;
    prev_last = inct_rlast_o;
    prev_v = inct_rvalid_o;
  end

  task automatic wait_drain(input int lim);
    bit done;
    done = 1'b0;
    for (int i = 0; i < lim && !done; i++) begin
      @(posedge clk); #1;
      done = sb.size() == 0 && !inct_rvalid_o;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain: got %0d beats pending rvalid=%b, need 0 and 0", sb.size(), inct_rvalid_o);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %b, need %b", name, got, need);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    inct_rready_i = 1'b1;
    miss_data_valid_i = 1'b0;
    miss_data_i = '0;
    miss_offset_i = '0;
    refresh();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({inct_rvalid_o, inct_rlast_o, inct_rdata_o, inct_rresp_o, hit_flag_fifo_rden_o, hit_data_fifo_rden_o, miss_data_ready_o} !== '0) begin
      bad++;
      $display("FAIL reset_outs: got v=%b l=%b d=%h r=%b pops=%b%b%b, need all 0", inct_rvalid_o, inct_rlast_o, inct_rdata_o, inct_rresp_o, hit_flag_fifo_rden_o, hit_data_fifo_rden_o, miss_data_ready_o);
    end
    rst = 1'b0;
    miss_data_valid_i = 1'b1;
    miss_data_i = mk_line(64'hDEAD, 64'h1);
    repeat (3) @(negedge clk);
    check_bit("idle_flag_pop", hit_flag_fifo_rden_o, 1'b0);
    check_bit("idle_miss_ready", miss_data_ready_o, 1'b0);
    check_bit("idle_rvalid", inct_rvalid_o, 1'b0);
    @(posedge clk); #1;
    miss_data_valid_i = 1'b0;
  endtask

  task automatic test_hit_timing();
    @(posedge clk); #1;
    queue_hit(6'h00, mk_line(64'h0, 64'h1111_1111_1111_1111), 1'b1);
    @(negedge clk);
    check_bit("t_flag_pop", hit_flag_fifo_rden_o, 1'b1);
    check_bit("t_data_pop_early", hit_data_fifo_rden_o, 1'b0);
    @(negedge clk);
    check_bit("t1_data_pop", hit_data_fifo_rden_o, 1'b1);
    check_bit("t1_flag_pop", hit_flag_fifo_rden_o, 1'b0);
    check_bit("t1_rvalid", inct_rvalid_o, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_bit("beat_rvalid", inct_rvalid_o, 1'b1);
      check_bit("beat_rlast", inct_rlast_o, i == 7);
    end
    @(negedge clk);
    check_bit("t10_rvalid", inct_rvalid_o, 1'b0);
    wait_drain(5);
  endtask

  task automatic test_cwf();
    @(posedge clk); #1;
    queue_hit(6'h28, mk_line(64'hA000, 64'h10), 1'b1);
    wait_drain(40);
  endtask

  task automatic test_hit_wait();
    logic [511:0] l;
    l = mk_line(64'h5500, 64'h21);
    @(posedge clk); #1;
    flag_q.push_back(1'b1);
    push_exp(6'h30, l);
    miss_data_valid_i = 1'b1;
    miss_data_i = mk_line(64'hBAD0, 64'h1);
    refresh();
    @(negedge clk);
    check_bit("hw_flag_pop", hit_flag_fifo_rden_o, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check_bit("hw_miss_ready", miss_data_ready_o, 1'b0);
      check_bit("hw_data_pop", hit_data_fifo_rden_o, 1'b0);
      check_bit("hw_rvalid", inct_rvalid_o, 1'b0);
    end
    @(posedge clk); #1;
    miss_data_valid_i = 1'b0;
    data_q.push_back({6'h30, l});
    refresh();
    wait_drain(40);
  endtask

  task automatic test_miss();
    logic [511:0] l;
    l = mk_line(64'hB0, 64'h3);
    @(posedge clk); #1;
    flag_q.push_back(1'b0);
    push_exp(6'h18, l);
    refresh();
    @(negedge clk);
    check_bit("m_flag_pop", hit_flag_fifo_rden_o, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_bit("m_ready_wait", miss_data_ready_o, 1'b1);
    end
    @(posedge clk); #1;
    miss_data_valid_i = 1'b1;
    miss_data_i = l;
    miss_offset_i = 6'h18;
    @(negedge clk);
    check_bit("m_ready_accept", miss_data_ready_o, 1'b1);
    check_bit("m_rvalid_accept", inct_rvalid_o, 1'b0);
    @(posedge clk); #1;
    miss_data_valid_i = 1'b0;
    @(negedge clk);
    check_bit("m_first_beat", inct_rvalid_o, 1'b1);
    check_bit("m_ready_send", miss_data_ready_o, 1'b0);
    wait_drain(40);
  endtask

  task automatic test_backpressure();
    int h0;
    bit done;
    @(posedge clk); #1;
    queue_hit(6'h10, mk_line(64'hC0DE, 64'h77), 1'b1);
    h0 = hs_cnt;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      inct_rready_i = (i % 4 == 0) || (i % 4 == 3);
      @(posedge clk); #1;
      done = sb.size() == 0 && !inct_rvalid_o;
    end
    inct_rready_i = 1'b1;
    total++;
    if (hs_cnt - h0 !== 8) begin
      bad++;
      $display("FAIL bp_count: got %0d handshakes, need 8", hs_cnt - h0);
    end
  endtask

  task automatic test_order();
    logic [511:0] l2;
    bit got;
    l2 = mk_line(64'h2222_0000, 64'h5);
    @(posedge clk); #1;
    queue_hit(6'h00, mk_line(64'h1111_0000, 64'h9), 1'b1);
    flag_q.push_back(1'b0);
    push_exp(6'h38, l2);
    queue_hit(6'h08, mk_line(64'h3333_0000, 64'hB), 1'b0);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      got = miss_data_ready_o;
    end
    check_bit("o_miss_ready", got, 1'b1);
    miss_data_valid_i = 1'b1;
    miss_data_i = l2;
    miss_offset_i = 6'h38;
    @(posedge clk); #1;
    miss_data_valid_i = 1'b0;
    data_q.push_back({6'h08, mk_line(64'h3333_0000, 64'hB)});
    refresh();
    wait_drain(100);
  endtask

  task automatic test_reset_mid();
    int h0;
    bit hit3;
    @(posedge clk); #1;
    queue_hit(6'h00, mk_line(64'hAAAA_0000, 64'h3), 1'b1);
    queue_hit(6'h20, mk_line(64'hBBBB_0000, 64'h7), 1'b1);
    h0 = hs_cnt;
    hit3 = 1'b0;
    for (int i = 0; i < 40 && !hit3; i++) begin
      @(posedge clk); #1;
      hit3 = hs_cnt - h0 == 3;
    end
    check_bit("rm_reach_beat4", hit3 && inct_rvalid_o, 1'b1);
    rst = 1'b1;
    #1;
    total++;
    if ({inct_rvalid_o, inct_rlast_o, inct_rdata_o, hit_flag_fifo_rden_o, hit_data_fifo_rden_o, miss_data_ready_o} !== '0) begin
      bad++;
      $display("FAIL rm_outs: got v=%b l=%b d=%h pops=%b%b%b, need all 0", inct_rvalid_o, inct_rlast_o, inct_rdata_o, hit_flag_fifo_rden_o, hit_data_fifo_rden_o, miss_data_ready_o);
    end
    while (sb.size() > 8) sb.delete(0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_drain(60);
  endtask

  initial begin
    test_reset();
    test_hit_timing();
    test_cwf();
    test_hit_wait();
    test_miss();
    test_backpressure();
    test_order();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
